// File: rtl/kr260_udmabuf_dma_pkg.sv
// kr260_udmabuf_dma_pkg: register map, STATUS bit positions, FSM states and fixed AXI
// attribute constants shared by the udmabuf DMA engine.
package kr260_udmabuf_dma_pkg;

  // Wishbone register word indices (only adr[3:0] is decoded)
  localparam logic [3:0] REG_DMA_STATUS  = 4'd0;
  localparam logic [3:0] REG_DMA_WSTART  = 4'd1;
  localparam logic [3:0] REG_DMA_RSTART  = 4'd2;
  localparam logic [3:0] REG_DMA_ADDR    = 4'd3;
  localparam logic [3:0] REG_DMA_WDATA0  = 4'd4;
  localparam logic [3:0] REG_DMA_WDATA1  = 4'd5;
  localparam logic [3:0] REG_DMA_RDATA0  = 4'd6;
  localparam logic [3:0] REG_DMA_RDATA1  = 4'd7;
  localparam logic [3:0] REG_DMA_CORE_ID = 4'd8;

  // STATUS bit positions
  localparam int unsigned STATUS_WBUSY_BIT = 0;
  localparam int unsigned STATUS_RBUSY_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata
  } dma_state_e;

  // Single 16-byte INCR beat, normal non-cacheable bufferable
  localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_NCB  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte-lane merge of a Wishbone write into an existing 64-bit register value
  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  sel);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/kr260_udmabuf_dma.sv
// kr260_udmabuf_dma: Wishbone-slave DMA engine moving one 128-bit word between the
// WDATA/RDATA registers and PS DDR through an AXI4 HP/HPC master port.
// Optional feature: define KR260_UDMABUF_DMA_ERROR_EN to latch a sticky AXI error flag
// in STATUS bit2 (cleared by any Wishbone write to STATUS).
module kr260_udmabuf_dma
  import kr260_udmabuf_dma_pkg::*;
#(
  parameter int unsigned WB_ADR_WIDTH    = 8,
  parameter int unsigned WB_DAT_WIDTH    = 64,
  parameter int unsigned AXI4_ID_WIDTH   = 6,
  parameter int unsigned AXI4_ADDR_WIDTH = 49,
  parameter logic [63:0] CORE_ID         = 64'h0000_0000_527a_0110
) (
  input  logic                       reset,
  input  logic                       clk,
  // Wishbone slave
  input  logic [WB_ADR_WIDTH-1:0]    s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]    s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]    s_wb_dat_o,
  input  logic [7:0]                 s_wb_sel_i,
  input  logic                       s_wb_we_i,
  input  logic                       s_wb_stb_i,
  output logic                       s_wb_ack_o,
  // AXI4 write address
  output logic [AXI4_ID_WIDTH-1:0]   m_axi4_awid,
  output logic [AXI4_ADDR_WIDTH-1:0] m_axi4_awaddr,
  output logic [7:0]                 m_axi4_awlen,
  output logic [2:0]                 m_axi4_awsize,
  output logic [1:0]                 m_axi4_awburst,
  output logic                       m_axi4_awlock,
  output logic [3:0]                 m_axi4_awcache,
  output logic [2:0]                 m_axi4_awprot,
  output logic [3:0]                 m_axi4_awqos,
  output logic                       m_axi4_awvalid,
  input  logic                       m_axi4_awready,
  // AXI4 write data
  output logic [127:0]               m_axi4_wdata,
  output logic [15:0]                m_axi4_wstrb,
  output logic                       m_axi4_wlast,
  output logic                       m_axi4_wvalid,
  input  logic                       m_axi4_wready,
  // AXI4 write response
  input  logic [AXI4_ID_WIDTH-1:0]   m_axi4_bid,
  input  logic [1:0]                 m_axi4_bresp,
  input  logic                       m_axi4_bvalid,
  output logic                       m_axi4_bready,
  // AXI4 read address
  output logic [AXI4_ID_WIDTH-1:0]   m_axi4_arid,
  output logic [AXI4_ADDR_WIDTH-1:0] m_axi4_araddr,
  output logic [7:0]                 m_axi4_arlen,
  output logic [2:0]                 m_axi4_arsize,
  output logic [1:0]                 m_axi4_arburst,
  output logic                       m_axi4_arlock,
  output logic [3:0]                 m_axi4_arcache,
  output logic [2:0]                 m_axi4_arprot,
  output logic [3:0]                 m_axi4_arqos,
  output logic                       m_axi4_arvalid,
  input  logic                       m_axi4_arready,
  // AXI4 read data
  input  logic [AXI4_ID_WIDTH-1:0]   m_axi4_rid,
  input  logic [127:0]               m_axi4_rdata,
  input  logic [1:0]                 m_axi4_rresp,
  input  logic                       m_axi4_rlast,
  input  logic                       m_axi4_rvalid,
  output logic                       m_axi4_rready
);

  dma_state_e                 r_state;
  dma_state_e                 w_state_nxt;
  logic [AXI4_ADDR_WIDTH-1:0] r_addr;
  logic [63:0]                r_wdata0;
  logic [63:0]                r_wdata1;
  logic [63:0]                r_rdata0;
  logic [63:0]                r_rdata1;
  logic                       r_awvalid;
  logic                       r_wvalid;

  logic [3:0]  w_idx;
  logic        w_wb_wr;
  logic        w_idle;
  logic        w_wstart;
  logic        w_rstart;
  logic        w_wbusy;
  logic        w_rbusy;
  logic        w_err;
  logic [63:0] w_addr_ext;
  logic [63:0] w_addr_merged;

  assign w_idx    = s_wb_adr_i[3:0];
  assign w_wb_wr  = s_wb_stb_i & s_wb_we_i;
  assign w_idle   = (r_state == StIdle);
  assign w_wstart = w_wb_wr & (w_idx == REG_DMA_WSTART) & s_wb_sel_i[0] & s_wb_dat_i[0] & w_idle;
  assign w_rstart = w_wb_wr & (w_idx == REG_DMA_RSTART) & s_wb_sel_i[0] & s_wb_dat_i[0] & w_idle;
  assign w_wbusy  = (r_state == StWrite) | (r_state == StWresp);
  assign w_rbusy  = (r_state == StRaddr) | (r_state == StRdata);

  assign s_wb_ack_o = s_wb_stb_i;

  // Zero-extend ADDR so byte lanes can be merged like the 64-bit registers
  always_comb begin
    w_addr_ext                        = '0;
    w_addr_ext[AXI4_ADDR_WIDTH-1:0]   = r_addr;
  end
  assign w_addr_merged = byte_merge(w_addr_ext, s_wb_dat_i, s_wb_sel_i);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state and response-side handshake outputs
  always_comb begin
    w_state_nxt    = r_state;
    m_axi4_arvalid = 1'b0;
    m_axi4_bready  = 1'b0;
    m_axi4_rready  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_wstart)      w_state_nxt = StWrite;
        else if (w_rstart) w_state_nxt = StRaddr;
      end
      StWrite: begin
        // AW and W complete independently; leave once neither is still pending
        if ((!r_awvalid || m_axi4_awready) && (!r_wvalid || m_axi4_wready)) begin
          w_state_nxt = StWresp;
        end
      end
      StWresp: begin
        m_axi4_bready = 1'b1;
        if (m_axi4_bvalid) w_state_nxt = StIdle;
      end
      StRaddr: begin
        m_axi4_arvalid = 1'b1;
        if (m_axi4_arready) w_state_nxt = StRdata;
      end
      StRdata: begin
        m_axi4_rready = 1'b1;
        if (m_axi4_rvalid) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // AW/W valids: raised together on start, each dropped on its own handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      if (w_wstart)                         r_awvalid <= 1'b1;
      else if (r_awvalid && m_axi4_awready) r_awvalid <= 1'b0;
      if (w_wstart)                         r_wvalid  <= 1'b1;
      else if (r_wvalid && m_axi4_wready)   r_wvalid  <= 1'b0;
    end
  end

  // Software-writable registers; frozen while busy so in-flight AXI fields stay stable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr   <= '0;
      r_wdata0 <= '0;
      r_wdata1 <= '0;
    end else if (w_wb_wr && w_idle) begin
      case (w_idx)
        REG_DMA_ADDR:   r_addr   <= {w_addr_merged[AXI4_ADDR_WIDTH-1:4], 4'b0000};
        REG_DMA_WDATA0: r_wdata0 <= byte_merge(r_wdata0, s_wb_dat_i, s_wb_sel_i);
        REG_DMA_WDATA1: r_wdata1 <= byte_merge(r_wdata1, s_wb_dat_i, s_wb_sel_i);
        default: ;
      endcase
    end
  end

  // Read-data capture on the R beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == StRdata && m_axi4_rvalid) begin
      r_rdata0 <= m_axi4_rdata[63:0];
      r_rdata1 <= m_axi4_rdata[127:64];
    end
  end

`ifdef KR260_UDMABUF_DMA_ERROR_EN
  logic r_err;

  // Sticky error flag on any non-OKAY response; a set in the same cycle wins over a clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if ((r_state == StWresp && m_axi4_bvalid && m_axi4_bresp != AXI_RESP_OKAY) ||
                 (r_state == StRdata && m_axi4_rvalid && m_axi4_rresp != AXI_RESP_OKAY)) begin
      r_err <= 1'b1;
    end else if (w_wb_wr && w_idx == REG_DMA_STATUS) begin
      r_err <= 1'b0;
    end
  end
  assign w_err = r_err;
`else
  logic w_unused_resp;
  assign w_err         = 1'b0;
  assign w_unused_resp = ^{m_axi4_bresp, m_axi4_rresp};
`endif

  // Wishbone read mux; purely combinational from registers
  always_comb begin
    s_wb_dat_o = '0;
    case (w_idx)
      REG_DMA_STATUS: begin
        s_wb_dat_o[STATUS_WBUSY_BIT] = w_wbusy;
        s_wb_dat_o[STATUS_RBUSY_BIT] = w_rbusy;
        s_wb_dat_o[STATUS_ERR_BIT]   = w_err;
      end
      REG_DMA_ADDR:    s_wb_dat_o = w_addr_ext;
      REG_DMA_WDATA0:  s_wb_dat_o = r_wdata0;
      REG_DMA_WDATA1:  s_wb_dat_o = r_wdata1;
      REG_DMA_RDATA0:  s_wb_dat_o = r_rdata0;
      REG_DMA_RDATA1:  s_wb_dat_o = r_rdata1;
      REG_DMA_CORE_ID: s_wb_dat_o = CORE_ID;
      default: ;
    endcase
  end

  // Fixed single-beat AXI attributes
  assign m_axi4_awid    = '0;
  assign m_axi4_awaddr  = r_addr;
  assign m_axi4_awlen   = 8'd0;
  assign m_axi4_awsize  = AXI_SIZE_16B;
  assign m_axi4_awburst = AXI_BURST_INCR;
  assign m_axi4_awlock  = 1'b0;
  assign m_axi4_awcache = AXI_CACHE_NCB;
  assign m_axi4_awprot  = 3'd0;
  assign m_axi4_awqos   = 4'd0;
  assign m_axi4_awvalid = r_awvalid;

  assign m_axi4_wdata   = {r_wdata1, r_wdata0};
  assign m_axi4_wstrb   = 16'hffff;
  assign m_axi4_wlast   = 1'b1;
  assign m_axi4_wvalid  = r_wvalid;

  assign m_axi4_arid    = '0;
  assign m_axi4_araddr  = r_addr;
  assign m_axi4_arlen   = 8'd0;
  assign m_axi4_arsize  = AXI_SIZE_16B;
  assign m_axi4_arburst = AXI_BURST_INCR;
  assign m_axi4_arlock  = 1'b0;
  assign m_axi4_arcache = AXI_CACHE_NCB;
  assign m_axi4_arprot  = 3'd0;
  assign m_axi4_arqos   = 4'd0;

  logic w_unused;
  assign w_unused = ^{s_wb_adr_i, m_axi4_bid, m_axi4_rid, m_axi4_rlast, w_addr_merged};

endmodule

// File: tb/tb_kr260_udmabuf_dma.sv
// tb_kr260_udmabuf_dma: table-driven register checks plus scoreboarded AXI transfers
// against a small AXI slave memory model with programmable AW/W backpressure.
`timescale 1ns/1ps
module tb_kr260_udmabuf_dma;
  import kr260_udmabuf_dma_pkg::*;

  localparam logic [63:0] CORE_ID_EXP = 64'h0000_0000_527a_0110;
  localparam logic [30:0] ATTR_EXP    = {8'd0, 3'b100, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 6'd0};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   s_wb_adr_i;
  logic [63:0]  s_wb_dat_i, s_wb_dat_o;
  logic [7:0]   s_wb_sel_i;
  logic         s_wb_we_i, s_wb_stb_i, s_wb_ack_o;
  logic [5:0]   awid, arid, bid, rid;
  logic [48:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, arsize, awprot, arprot;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awlock, arlock;
  logic [3:0]   awcache, arcache, awqos, arqos;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;

  always #5 clk = ~clk;

  kr260_udmabuf_dma dut (
    .reset(reset), .clk(clk),
    .s_wb_adr_i(s_wb_adr_i), .s_wb_dat_i(s_wb_dat_i), .s_wb_dat_o(s_wb_dat_o),
    .s_wb_sel_i(s_wb_sel_i), .s_wb_we_i(s_wb_we_i), .s_wb_stb_i(s_wb_stb_i),
    .s_wb_ack_o(s_wb_ack_o),
    .m_axi4_awid(awid), .m_axi4_awaddr(awaddr), .m_axi4_awlen(awlen), .m_axi4_awsize(awsize),
    .m_axi4_awburst(awburst), .m_axi4_awlock(awlock), .m_axi4_awcache(awcache),
    .m_axi4_awprot(awprot), .m_axi4_awqos(awqos), .m_axi4_awvalid(awvalid),
    .m_axi4_awready(awready),
    .m_axi4_wdata(wdata), .m_axi4_wstrb(wstrb), .m_axi4_wlast(wlast), .m_axi4_wvalid(wvalid),
    .m_axi4_wready(wready),
    .m_axi4_bid(bid), .m_axi4_bresp(bresp), .m_axi4_bvalid(bvalid), .m_axi4_bready(bready),
    .m_axi4_arid(arid), .m_axi4_araddr(araddr), .m_axi4_arlen(arlen), .m_axi4_arsize(arsize),
    .m_axi4_arburst(arburst), .m_axi4_arlock(arlock), .m_axi4_arcache(arcache),
    .m_axi4_arprot(arprot), .m_axi4_arqos(arqos), .m_axi4_arvalid(arvalid),
    .m_axi4_arready(arready),
    .m_axi4_rid(rid), .m_axi4_rdata(rdata), .m_axi4_rresp(rresp), .m_axi4_rlast(rlast),
    .m_axi4_rvalid(rvalid), .m_axi4_rready(rready)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model + scoreboard ----------------
  typedef struct {
    logic [48:0]  addr;
    logic [127:0] data;
  } wr_exp_t;

  wr_exp_t      wq[$];
  logic [48:0]  rq[$];
  logic [127:0] mem[logic [48:0]];

  int          aw_wait = 0, w_wait = 0;
  logic [1:0]  bresp_knob = 2'b00;
  int          aw_cnt, w_cnt;
  int          aw_count = 0, w_count = 0, b_count = 0, ar_count = 0, r_count = 0;
  bit          aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_seen, w_seen, ar_pend;
  logic [48:0]  aw_addr_s, ar_addr_s;
  logic [30:0]  aw_attr_s, ar_attr_s;
  logic [127:0] w_data_s;
  logic [16:0]  w_strb_last_s;

  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rresp = 0; rid = 0; rlast = 0; rdata = '0;
    aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
    aw_seen = 0; w_seen = 0; ar_pend = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        aw_seen = 0; w_seen = 0; ar_pend = 0; aw_cnt = 0; w_cnt = 0;
        continue;
      end
      // effects of handshakes at the previous posedge
      if (b_fire) bvalid = 0;
      if (r_fire) begin rvalid = 0; rlast = 0; end
      if (aw_seen && w_seen) begin
        aw_seen = 0; w_seen = 0;
        mem[aw_addr_s] = w_data_s;
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %0h with no expected write", aw_addr_s);
        end else begin
          wr_exp_t e;
          e = wq.pop_front();
          check("aw_addr", aw_addr_s, e.addr);
          check("w_data", w_data_s, e.data);
          check("w_strb_last", w_strb_last_s, {16'hffff, 1'b1});
          check("aw_attr", aw_attr_s, ATTR_EXP);
        end
        bvalid = 1; bresp = bresp_knob;
      end
      if (ar_pend) begin
        ar_pend = 0;
        rdata  = mem.exists(ar_addr_s) ? mem[ar_addr_s] : '0;
        rvalid = 1; rresp = AXI_RESP_OKAY; rlast = 1;
      end
      // readies for the next edge
      awready = awvalid && (aw_cnt >= aw_wait);
      wready  = wvalid && (w_cnt >= w_wait);
      arready = arvalid;
      if (awvalid && !awready) aw_cnt++; else aw_cnt = 0;
      if (wvalid && !wready) w_cnt++; else w_cnt = 0;
      // handshakes that will occur at the next edge
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (aw_fire) begin
        aw_count++; aw_seen = 1; aw_addr_s = awaddr;
        aw_attr_s = {awlen, awsize, awburst, awlock, awcache, awprot, awqos, awid};
      end
      if (w_fire) begin
        w_count++; w_seen = 1; w_data_s = wdata; w_strb_last_s = {wstrb, wlast};
      end
      if (b_fire) b_count++;
      if (r_fire) r_count++;
      if (ar_fire) begin
        ar_count++; ar_pend = 1; ar_addr_s = araddr;
        ar_attr_s = {arlen, arsize, arburst, arlock, arcache, arprot, arqos, arid};
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_read: addr %0h with no expected read", araddr);
        end else begin
          check("ar_addr", ar_addr_s, rq.pop_front());
          check("ar_attr", ar_attr_s, ATTR_EXP);
        end
      end
    end
  end

  // ---------------- Wishbone tasks ----------------
  task automatic wb_write(input logic [7:0] adr, input logic [63:0] dat, input logic [7:0] sel);
    s_wb_adr_i = adr; s_wb_dat_i = dat; s_wb_sel_i = sel; s_wb_we_i = 1; s_wb_stb_i = 1;
    @(posedge clk); #1;
    s_wb_stb_i = 0; s_wb_we_i = 0;
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [63:0] dat);
    s_wb_adr_i = adr; s_wb_we_i = 0; s_wb_sel_i = 8'hff; s_wb_stb_i = 1;
    #2;
    dat = s_wb_dat_o;
    @(posedge clk); #1;
    s_wb_stb_i = 0;
  endtask

  int exp_b = 0, exp_r = 0;

  // Poll STATUS busy bits with a bounded budget; on idle check the response beats arrived
  task automatic wait_idle(input string name);
    logic [63:0] st;
    bit done;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      wb_read({4'd0, REG_DMA_STATUS}, st);
      if ((st & 64'h3) == 64'h0) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: still busy after 200 polls", name);
    end else begin
      check({name, "_resp_beats"}, {64'(b_count), 64'(r_count)}, {64'(exp_b), 64'(exp_r)});
    end
  endtask

  task automatic do_write(input logic [48:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                          input string name);
    logic [63:0] st;
    int aw0;
    aw0 = aw_count;
    wb_write({4'd0, REG_DMA_ADDR}, 64'(addr), 8'hff);
    wb_write({4'd0, REG_DMA_WDATA0}, d0, 8'hff);
    wb_write({4'd0, REG_DMA_WDATA1}, d1, 8'hff);
    wq.push_back('{addr, {d1, d0}});
    exp_b++;
    wb_write({4'd0, REG_DMA_WSTART}, 64'd1, 8'h01);
    wb_read({4'd0, REG_DMA_STATUS}, st);
    check({name, "_busy"}, st, 64'd1);
    wait_idle(name);
    check({name, "_aw_w_once"}, {64'(aw_count - aw0), 64'(w_count - aw0)}, {64'd1, 64'd1});
  endtask

  task automatic do_read(input logic [48:0] addr, input logic [63:0] d0, input logic [63:0] d1,
                         input string name);
    logic [63:0] st, r0, r1;
    wb_write({4'd0, REG_DMA_ADDR}, 64'(addr), 8'hff);
    rq.push_back(addr);
    exp_r++;
    wb_write({4'd0, REG_DMA_RSTART}, 64'd1, 8'h01);
    wb_read({4'd0, REG_DMA_STATUS}, st);
    check({name, "_busy"}, st, 64'd2);
    wait_idle(name);
    wb_read({4'd0, REG_DMA_RDATA0}, r0);
    wb_read({4'd0, REG_DMA_RDATA1}, r1);
    check({name, "_rdata"}, {r1, r0}, {d1, d0});
  endtask

  // ---------------- Main test ----------------
  typedef struct {
    bit          we;
    logic [7:0]  adr;
    logic [7:0]  sel;
    logic [63:0] dat;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [63:0] rd;
    int aw0;
    s_wb_adr_i = 0; s_wb_dat_i = 0; s_wb_sel_i = 0; s_wb_we_i = 0; s_wb_stb_i = 0;

    vt.push_back('{1'b0, 8'd8,  8'hff, 64'd0, CORE_ID_EXP});
    vt.push_back('{1'b0, 8'd15, 8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'd0,  8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'd3,  8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'd6,  8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b0, 8'd7,  8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b1, 8'd3,  8'hff, 64'h123, 64'd0});
    vt.push_back('{1'b0, 8'd3,  8'hff, 64'd0, 64'h120});
    vt.push_back('{1'b1, 8'd4,  8'h0f, 64'h1111_2222_3333_4444, 64'd0});
    vt.push_back('{1'b0, 8'd4,  8'hff, 64'd0, 64'h0000_0000_3333_4444});
    vt.push_back('{1'b1, 8'd4,  8'hf0, 64'haaaa_aaaa_bbbb_bbbb, 64'd0});
    vt.push_back('{1'b0, 8'd4,  8'hff, 64'd0, 64'haaaa_aaaa_3333_4444});
    vt.push_back('{1'b1, 8'd6,  8'hff, 64'hffff_ffff_ffff_ffff, 64'd0});
    vt.push_back('{1'b0, 8'd6,  8'hff, 64'd0, 64'd0});
    vt.push_back('{1'b1, 8'd3,  8'hff, 64'hffff_ffff_ffff_ffff, 64'd0});
    vt.push_back('{1'b0, 8'd3,  8'hff, 64'd0, 64'h0001_ffff_ffff_fff0});
    vt.push_back('{1'b1, 8'd3,  8'h01, 64'h0, 64'd0});
    vt.push_back('{1'b0, 8'd3,  8'hff, 64'd0, 64'h0001_ffff_ffff_ff00});
    vt.push_back('{1'b0, 8'd9,  8'hff, 64'd0, 64'd0});

    repeat (3) @(posedge clk);
    #1;
    check("reset_valids_readies", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    reset = 0;
    @(posedge clk); #1;

    s_wb_stb_i = 1; s_wb_adr_i = 8'd0; #1;
    check("ack_follows_stb", s_wb_ack_o, 1'b1);
    s_wb_stb_i = 0; #1;
    check("ack_low", s_wb_ack_o, 1'b0);
    @(posedge clk); #1;

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].we) begin
        wb_write(vt[i].adr, vt[i].dat, vt[i].sel);
      end else begin
        wb_read(vt[i].adr, rd);
        check($sformatf("vec%0d_idx%0d", i, vt[i].adr), rd, vt[i].exp);
      end
    end

    // RSTART without sel[0] must not start
    wb_write({4'd0, REG_DMA_RSTART}, 64'd1, 8'h02);
    wb_read({4'd0, REG_DMA_STATUS}, rd);
    check("rstart_no_sel0", rd, 64'd0);

    // Basic write / read-back, then a second region without corrupting the first
    do_write(49'h0, 64'hfedcba98_76543210, 64'h01234567_89abcdef, "wr0");
    do_read(49'h0, 64'hfedcba98_76543210, 64'h01234567_89abcdef, "rd0");
    do_write(49'h100, 64'h55aa55aa_55aa55aa, 64'haa55aa55_aa55aa55, "wr100");
    do_read(49'h100, 64'h55aa55aa_55aa55aa, 64'haa55aa55_aa55aa55, "rd100");
    do_read(49'h0, 64'hfedcba98_76543210, 64'h01234567_89abcdef, "rd0_again");

    // Backpressure: W before AW, then AW before W
    aw_wait = 5; w_wait = 0;
    do_write(49'h40, 64'h1111_1111_0000_0001, 64'h2222_2222_0000_0002, "bp_w_first");
    aw_wait = 0; w_wait = 5;
    do_write(49'h50, 64'h3333_3333_0000_0003, 64'h4444_4444_0000_0004, "bp_aw_first");

    // Writes while busy must be ignored
    aw_wait = 8; w_wait = 8;
    aw0 = aw_count;
    wb_write({4'd0, REG_DMA_ADDR}, 64'h80, 8'hff);
    wb_write({4'd0, REG_DMA_WDATA0}, 64'h0bad_0000_0000_0001, 8'hff);
    wb_write({4'd0, REG_DMA_WDATA1}, 64'h0bad_0000_0000_0002, 8'hff);
    wq.push_back('{49'h80, {64'h0bad_0000_0000_0002, 64'h0bad_0000_0000_0001}});
    exp_b++;
    wb_write({4'd0, REG_DMA_WSTART}, 64'd1, 8'h01);
    wb_write({4'd0, REG_DMA_WSTART}, 64'd1, 8'h01);
    wb_write({4'd0, REG_DMA_ADDR}, 64'h200, 8'hff);
    wb_write({4'd0, REG_DMA_WDATA0}, 64'hdead_beef, 8'hff);
    wb_read({4'd0, REG_DMA_ADDR}, rd);
    check("busy_addr_ignored", rd, 64'h80);
    check("busy_axi_addr_stable", {awaddr, araddr}, {49'h80, 49'h80});
    wait_idle("busy_wr");
    repeat (4) @(posedge clk);
    #1;
    check("busy_single_aw", aw_count - aw0, 1);
    aw_wait = 0; w_wait = 0;

    // Error response handling
    bresp_knob = 2'b10;
    do_write(49'h300, 64'h0e0e, 64'h0f0f, "err_wr");
    bresp_knob = 2'b00;
    wb_read({4'd0, REG_DMA_STATUS}, rd);
`ifdef KR260_UDMABUF_DMA_ERROR_EN
    check("err_status", rd, 64'd4);
`else
    check("err_status", rd, 64'd0);
`endif
    wb_write({4'd0, REG_DMA_STATUS}, 64'd0, 8'hff);
    wb_read({4'd0, REG_DMA_STATUS}, rd);
    check("err_cleared", rd, 64'd0);

    // Reset in the middle of a write
    aw_wait = 1000; w_wait = 1000;
    wb_write({4'd0, REG_DMA_ADDR}, 64'h400, 8'hff);
    wb_write({4'd0, REG_DMA_WSTART}, 64'd1, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_valids", {awvalid, wvalid}, 2'b11);
    reset = 1;
    #1;
    check("reset_valids_now", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    wq.delete();
    aw_wait = 0; w_wait = 0;
    @(posedge clk); #1;
    wb_read({4'd0, REG_DMA_STATUS}, rd);
    check("post_reset_status", rd, 64'd0);
    check("post_reset_valids", {awvalid, wvalid, arvalid}, 3'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule

// File: doc/kr260_udmabuf_dma.md
# kr260_udmabuf_dma

- Wishbone-slave DMA engine: transfers one 128-bit word between two 64-bit data registers and the udmabuf region in PS DDR.
- Sits downstream of the peripheral Wishbone bus and upstream of an AXI4 HP/HPC port. Instantiated twice, as DMA0 (word base 0x000) and DMA1 (word base 0x100).
- Software programs ADDR and WDATA0/1, writes WSTART or RSTART, then polls STATUS until it reads 0.

## Interface
Parameters:
- WB_ADR_WIDTH, 8: Wishbone word-address width; only bits [3:0] are decoded.
- WB_DAT_WIDTH, 64: Wishbone data width; fixed at 64.
- AXI4_ID_WIDTH, 6: AXI ID width.
- AXI4_ADDR_WIDTH, 49: AXI address width.
- CORE_ID, 64'h0000_0000_527a_0110: value returned by the CORE_ID register.

Ports (clock and reset first):
- reset  in  1  asynchronous, active-high reset.
- clk  in  1  single clock; every signal is synchronous to it.
- s_wb_adr_i, s_wb_dat_i, s_wb_dat_o, s_wb_sel_i[8], s_wb_we_i, s_wb_stb_i, s_wb_ack_o: Wishbone slave.
- m_axi4_aw*: id, addr, len, size, burst, lock, cache, prot, qos, valid, ready.
- m_axi4_w*: data[128], strb[16], last, valid, ready.
- m_axi4_b*: id, resp, valid, ready.
- m_axi4_ar*: same field set as aw*.
- m_axi4_r*: id, data[128], resp, last, valid, ready.

## Operation
Register map (word index):
- 0 STATUS: bit0 = write busy, bit1 = read busy, bit2 = error.
- 1 WSTART, 2 RSTART.
- 3 ADDR.
- 4 WDATA0, 5 WDATA1.
- 6 RDATA0, 7 RDATA1.
- 8 CORE_ID.
- Unmapped indices read 0.

Register writes:
- Apply byte-wise per s_wb_sel_i.
- Writing 1 to bit0 of WSTART or RSTART (with sel[0] set) starts an operation.
- ADDR: bits [3:0] always read 0 (128-bit alignment). Bits above AXI4_ADDR_WIDTH are dropped.

Fixed AXI attributes:
- len=0, size=3'b100, burst=INCR, cache=4'b0011, lock=0, prot=0, qos=0, id=0.
- wstrb all ones, wlast=1.
- wdata = {WDATA1, WDATA0}.
- bready=1 and rready=1 while waiting for the response.

FSM states:
- IDLE: on WSTART go to WRITE, asserting awvalid and wvalid together. On RSTART go to RADDR, asserting arvalid.
- WRITE: awvalid drops on aw handshake; wvalid drops on w handshake. The two are independent, in either order or the same cycle. When both are done, go to WRESP.
- WRESP: on bvalid go to IDLE.
- RADDR: on ar handshake go to RDATA.
- RDATA: on rvalid capture RDATA0 = rdata[63:0] and RDATA1 = rdata[127:64], then go to IDLE.
- Busy bit = (state != IDLE), reported on bit0 for write and bit1 for read.

Boundary rules:
- WSTART or RSTART while busy: ignored.
- Writes to ADDR or WDATA while busy: ignored, so in-flight AXI fields stay stable.
- RDATA writes: ignored (read-only).
- Reset mid-operation: FSM returns to IDLE and all valids deassert immediately. Outstanding AXI responses are not tracked; software must not reset during a transfer.

## Timing
- s_wb_ack_o = s_wb_stb_i: zero wait states.
- Read data is combinational from registers. Register writes take effect at the ack posedge.
- Start-to-valid latency: awvalid, wvalid or arvalid rises the cycle after the WSTART/RSTART ack edge. A STATUS read on that next cycle already shows busy.
- Completion: busy clears the cycle after the bvalid or rvalid beat. RDATA is valid when busy clears.
- Minimum write duration with all-ready AXI: 3 cycles after start.
- Reset values: all valids 0, all readies 0, STATUS 0, ADDR/WDATA/RDATA 0.

## Configuration
Macro KR260_UDMABUF_DMA_ERROR_EN:
- Defined: STATUS bit2 latches when bresp or rresp != OKAY. It is sticky and cleared by any Wishbone write to STATUS.
- Undefined: bresp and rresp are ignored, and bit2 always reads 0.

## Structure
- Package kr260_udmabuf_dma_pkg holds:
  - register index localparams (REG_DMA_STATUS … REG_DMA_CORE_ID);
  - STATUS bit positions;
  - FSM state enum;
  - AXI constants (size, burst, cache, OKAY).
- Single flat module; no sub-module is natural at this size.

## Test plan
- Read CORE_ID → 64'h0000_0000_527a_0110. Read index 15 → 0.
- ADDR=0x0, WDATA0=fedcba98_76543210, WDATA1=01234567_89abcdef, WSTART → one AW beat at 0x0, with wdata=0123456789abcdef_fedcba9876543210 and wstrb=16'hffff. STATUS reads 1 until B, then 0.
- RSTART at 0x0 against a memory model → RDATA0 and RDATA1 equal the written values. Repeat with DMA1 at 0x100 using 55aa…/aa55… without corrupting 0x0.
- Backpressure: wready high 5 cycles before awready, then the reverse ordering. Each handshake occurs exactly once, and busy clears only after B.
- While busy: write WSTART again and write ADDR=0x200 → no second AW beat and araddr/awaddr unchanged. ADDR=0x123 → reads 0x120.
- With KR260_UDMABUF_DMA_ERROR_EN: bresp=SLVERR → STATUS=4 after completion; a write to STATUS clears it to 0. Without the macro, STATUS=0.
- Assert reset while in WRITE → all valids 0 within the same cycle and STATUS=0 afterwards.
